// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state encoding
// and default operand/product widths.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoadQ = 2'd1,
        StCalc  = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefaultWidth = 6;
    localparam int unsigned ProductWidth = 2 * DefaultWidth;

endpackage

// File: rtl/multiplier_controller.sv
// Controller FSM and iteration counter for the shift-and-add multiplier.
// Drives the datapath load/clear/step enables plus the busy and done flags.
module multiplier_controller
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic m_ld,
    output logic q_ld,
    output logic a_clr,
    output logic step_en,
    output logic done,
    output logic busy
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_ld    = 1'b0;
        q_ld    = 1'b0;
        a_clr   = 1'b0;
        step_en = 1'b0;
        done    = 1'b0;
        busy    = (state_q != StIdle);
        case (state_q)
            StIdle: begin
                // start is only honoured here; requests in other states are dropped
                if (start) begin
                    m_ld    = 1'b1;
                    state_d = StLoadQ;
                end
            end
            StLoadQ: begin
                q_ld    = 1'b1;
                a_clr   = 1'b1;
                cnt_d   = '0;
                state_d = StCalc;
            end
            StCalc: begin
                step_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: operands arrive on a shared bus
// (multiplicand, then multiplier), one add-or-skip plus right shift per clock.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   In_bus,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Product
);

    logic             m_ld, q_ld, a_clr, step_en;
    logic             c_q;
    logic [WIDTH-1:0] a_q, q_q, m_q;
    logic [WIDTH:0]   sum;

    multiplier_controller #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .m_ld    (m_ld),
        .q_ld    (q_ld),
        .a_clr   (a_clr),
        .step_en (step_en),
        .done    (done),
        .busy    (busy)
    );

    // c_q is always cleared by the shift, so {c_q, a_q} is the zero-extended accumulator
    always_comb begin
        sum = {c_q, a_q};
        if (q_q[0]) begin
            sum = {c_q, a_q} + {1'b0, m_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= 1'b0;
            a_q <= '0;
            q_q <= '0;
            m_q <= '0;
        end else if (m_ld) begin
            m_q <= In_bus;
        end else if (q_ld && a_clr) begin
            q_q <= In_bus;
            a_q <= '0;
            c_q <= 1'b0;
        end else if (step_en) begin
            {c_q, a_q, q_q} <= {1'b0, sum, q_q[WIDTH-1:1]};
        end
    end

    assign Product = {a_q, q_q};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed, table-driven bench for shift_add_multiplier with hand-computed products,
// latency/busy checks and sequences for ignored starts and mid-operation reset.
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  In_bus;
    logic        busy;
    logic        done;
    logic [11:0] Product;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(
        .WIDTH (6),
        .CNT_W (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .In_bus  (In_bus),
        .busy    (busy),
        .done    (done),
        .Product (Product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [15:0] poke;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Entered with the DUT idle; start is driven for cycle 0. poke[k] drives start in cycle k.
    // Returns sampled in the first idle cycle after done.
    task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [15:0] poke,
                          output logic [11:0] prod, output int lat, output int busy_cycles,
                          output logic idle_busy, output logic idle_done,
                          output logic [11:0] idle_prod);
        start       = 1'b1;
        In_bus      = a;
        lat         = -1;
        busy_cycles = 0;
        prod        = '0;
        for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
            @(posedge clk);
            #1;
            start  = poke[cyc];
            In_bus = (cyc == 1) ? b : 6'h15;
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat  = cyc;
                prod = Product;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        idle_busy = busy;
        idle_done = done;
        idle_prod = Product;
    endtask

    logic [11:0] prod, idle_prod;
    int          lat, busy_cycles, done_cnt;
    logic        idle_busy, idle_done;

    initial begin
        vecs[0] = '{a: 6'd6,  b: 6'd7,  poke: 16'h0000, exp: 12'd42};
        vecs[1] = '{a: 6'd63, b: 6'd63, poke: 16'h0000, exp: 12'd3969};
        vecs[2] = '{a: 6'd0,  b: 6'd45, poke: 16'h0000, exp: 12'd0};
        vecs[3] = '{a: 6'd37, b: 6'd1,  poke: 16'h0000, exp: 12'd37};
        vecs[4] = '{a: 6'd1,  b: 6'd63, poke: 16'h0000, exp: 12'd63};
        vecs[5] = '{a: 6'd5,  b: 6'd9,  poke: 16'h0028, exp: 12'd45};
        vecs[6] = '{a: 6'd13, b: 6'd11, poke: 16'h0000, exp: 12'd143};
        // back-to-back pair; the second holds start through its done cycle
        vecs[7] = '{a: 6'd20, b: 6'd3,  poke: 16'h0000, exp: 12'd60};
        vecs[8] = '{a: 6'd63, b: 6'd2,  poke: 16'h0100, exp: 12'd126};

        rst    = 1'b1;
        start  = 1'b0;
        In_bus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(Product), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // runs chain with no gap: each starts in the idle cycle right after the previous done
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].poke, prod, lat, busy_cycles,
                   idle_busy, idle_done, idle_prod);
            check($sformatf("v%0d_product", i), 32'(prod), 32'(vecs[i].exp));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_cycles), 32'd8);
            check($sformatf("v%0d_idle_busy", i), 32'(idle_busy), 32'd0);
            check($sformatf("v%0d_idle_done", i), 32'(idle_done), 32'd0);
            check($sformatf("v%0d_product_hold", i), 32'(idle_prod), 32'(vecs[i].exp));
        end

        // reset in CALC (cycle 4) aborts the operation without a done pulse
        @(posedge clk);
        #1;
        start  = 1'b1;
        In_bus = 6'd5;
        @(posedge clk);
        #1;
        start  = 1'b0;
        In_bus = 6'd9;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(Product), 32'd0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort_no_activity", 32'(done_cnt), 32'd0);

        @(posedge clk);
        #1;
        run_op(6'd10, 6'd12, 16'h0000, prod, lat, busy_cycles, idle_busy, idle_done, idle_prod);
        check("post_reset_product", 32'(prod), 32'd120);
        check("post_reset_latency", 32'(lat), 32'd8);
        check("post_reset_idle_busy", 32'(idle_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got hang, expected finish");
        $fatal(1);
    end

endmodule
